// File: rtl/dc_token_ring_reader.sv
// rtl/dc_token_ring_reader.sv - read-side controller of the dual-clock token-ring FIFO
module dc_token_ring_reader #(
    parameter int DATA_WIDTH   = 32,
    parameter int BUFFER_DEPTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [BUFFER_DEPTH-1:0] write_token,
    output logic [BUFFER_DEPTH-1:0] read_pointer,
    input  logic [DATA_WIDTH-1:0]   read_data,
    output logic [DATA_WIDTH-1:0]   data_o,
    output logic                    valid_o,
    input  logic                    ready_i,
    output logic                    empty,
    output logic                    token_error
);

    typedef enum logic {
        EMPTY_REG = 1'b0,
        FULL_REG  = 1'b1
    } out_state_t;

    out_state_t                state_q;
    logic [BUFFER_DEPTH-1:0]   read_pointer_q;
    logic [DATA_WIDTH-1:0]     data_q;
    logic                      token_error_q;
    logic                      token_err_now;
    logic                      take;

    assign token_err_now = ($countones(write_token) != 1);

    // A faulty token freezes the reader by forcing the buffer to look empty.
    assign empty = (read_pointer_q == write_token) || token_error_q;
    assign take  = !empty && ((state_q == EMPTY_REG) || ready_i);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= EMPTY_REG;
            read_pointer_q <= {{(BUFFER_DEPTH-1){1'b0}}, 1'b1};
            data_q         <= '0;
            token_error_q  <= 1'b0;
        end else begin
            if (token_err_now) begin
                token_error_q <= 1'b1;
            end
            if (take) begin
                state_q        <= FULL_REG;
                data_q         <= read_data;
                read_pointer_q <= {read_pointer_q[BUFFER_DEPTH-2:0], read_pointer_q[BUFFER_DEPTH-1]};
            end else if ((state_q == FULL_REG) && ready_i) begin
                state_q <= EMPTY_REG;
            end
        end
    end

    assign read_pointer = read_pointer_q;
    assign data_o       = data_q;
    assign valid_o      = (state_q == FULL_REG);
    assign token_error  = token_error_q;

endmodule

// File: tb/tb_dc_token_ring_reader.sv
// tb/tb_dc_token_ring_reader.sv - scoreboard bench for dc_token_ring_reader
module tb_dc_token_ring_reader;
    localparam int DW = 32;
    localparam int BD = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [BD-1:0] write_token;
    logic [BD-1:0] read_pointer;
    logic [DW-1:0] read_data;
    logic [DW-1:0] data_o;
    logic          valid_o;
    logic          ready_i;
    logic          empty;
    logic          token_error;

    logic [DW-1:0] mem [BD];
    logic [2:0]    rd_idx;
    int            wi;
    logic [DW-1:0] exp_q [$];
    int            vectors = 0;
    int            miscompares = 0;

    dc_token_ring_reader #(.DATA_WIDTH(DW), .BUFFER_DEPTH(BD)) dut (
        .clk(clk), .rst(rst), .write_token(write_token), .read_pointer(read_pointer),
        .read_data(read_data), .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i),
        .empty(empty), .token_error(token_error)
    );

    always #5 clk = ~clk;

    // Shared buffer: the reader sees the slot addressed by its one-hot pointer.
    always_comb begin
        rd_idx = 3'd0;
        for (int i = 0; i < BD; i++) begin
            if (read_pointer[i]) rd_idx = 3'(i);
        end
    end
    assign read_data = mem[rd_idx];

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [BD-1:0] onehot(input int idx);
        logic [BD-1:0] v;
        v = '0;
        v[idx % BD] = 1'b1;
        return v;
    endfunction

    // Writer model: store word, advance the token, expect it in order.
    task automatic write_word(input logic [DW-1:0] val, input bit push);
        mem[wi] = val;
        wi = (wi + 1) % BD;
        write_token = onehot(wi);
        if (push) exp_q.push_back(val);
    endtask

    task automatic do_reset();
        step();
        rst = 1'b1;
        exp_q.delete();
        wi = 0;
        write_token = onehot(0);
        step();
        rst = 1'b0;
    endtask

    // Monitor: every presented word must be the oldest outstanding expected word.
    always @(negedge clk) begin
        if (!rst && valid_o) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_beat", {32'd0, data_o}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                chk("data_o", {32'd0, data_o}, {32'd0, exp_q[0]});
                if (ready_i) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [DW-1:0] w;
        int            cyc;
        for (int i = 0; i < BD; i++) mem[i] = '0;
        rst = 1'b1;
        ready_i = 1'b0;
        wi = 0;
        write_token = onehot(0);
        step();
        step();
        rst = 1'b0;

        // Reset state and idle
        repeat (10) begin
            @(negedge clk);
            chk("idle_rp", 64'(read_pointer), 64'h01);
            chk("idle_valid", 64'(valid_o), 64'd0);
            chk("idle_empty", 64'(empty), 64'd1);
            chk("idle_terr", 64'(token_error), 64'd0);
        end

        // Single word latency
        step();
        ready_i = 1'b1;
        write_word(32'hDEADBEEF, 1);
        @(negedge clk);
        chk("single_valid_N", 64'(valid_o), 64'd0);
        @(negedge clk);
        chk("single_valid_N1", 64'(valid_o), 64'd1);
        chk("single_rp", 64'(read_pointer), 64'h02);
        @(negedge clk);
        chk("single_valid_N2", 64'(valid_o), 64'd0);

        // Streaming with wrap
        do_reset();
        step();
        for (int i = 0; i < 7; i++) write_word(DW'(i), 1);
        chk("stream_token", 64'(write_token), 64'h80);
        @(negedge clk);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            chk("stream_valid", 64'(valid_o), 64'd1);
        end
        @(negedge clk);
        chk("stream_end_valid", 64'(valid_o), 64'd0);
        chk("stream_end_rp", 64'(read_pointer), 64'h80);
        step();
        write_word(32'd7, 1);
        @(negedge clk);
        @(negedge clk);
        chk("wrap_valid", 64'(valid_o), 64'd1);
        @(negedge clk);
        chk("wrap_rp", 64'(read_pointer), 64'h01);
        chk("wrap_valid_end", 64'(valid_o), 64'd0);

        // Backpressure: data held, pointer advanced once
        step();
        ready_i = 1'b0;
        for (int i = 0; i < 3; i++) write_word($urandom, 1);
        @(negedge clk);
        repeat (5) begin
            @(negedge clk);
            chk("bp_valid", 64'(valid_o), 64'd1);
            chk("bp_rp", 64'(read_pointer), 64'h02);
        end
        step();
        ready_i = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("bp_release_valid", 64'(valid_o), 64'd1);
        end
        @(negedge clk);
        chk("bp_done_valid", 64'(valid_o), 64'd0);
        chk("bp_done_queue", 64'(exp_q.size()), 64'd0);

        // Token fault while a word is held
        do_reset();
        step();
        ready_i = 1'b0;
        write_word(32'hCAFE_F00D, 1);
        @(negedge clk);
        @(negedge clk);
        chk("fault_pre_valid", 64'(valid_o), 64'd1);
        chk("fault_pre_rp", 64'(read_pointer), 64'h02);
        step();
        write_token = 8'h03;
        step();
        write_token = onehot(wi);
        repeat (4) begin
            @(negedge clk);
            chk("fault_terr", 64'(token_error), 64'd1);
            chk("fault_empty", 64'(empty), 64'd1);
            chk("fault_rp", 64'(read_pointer), 64'h02);
        end
        step();
        write_word(32'h1234_5678, 0);
        ready_i = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("fault_drained_valid", 64'(valid_o), 64'd0);
        chk("fault_frozen_rp", 64'(read_pointer), 64'h02);
        chk("fault_sticky", 64'(token_error), 64'd1);
        do_reset();
        @(negedge clk);
        chk("fault_cleared", 64'(token_error), 64'd0);

        // Reset mid-stream
        step();
        ready_i = 1'b0;
        write_word(32'hA5A5_0001, 1);
        write_word(32'hA5A5_0002, 1);
        @(negedge clk);
        @(negedge clk);
        chk("mid_pre_valid", 64'(valid_o), 64'd1);
        do_reset();
        @(negedge clk);
        chk("mid_valid", 64'(valid_o), 64'd0);
        chk("mid_data", 64'(data_o), 64'd0);
        chk("mid_rp", 64'(read_pointer), 64'h01);

        // Randomized traffic against the queue model
        for (int c = 0; c < 3000; c++) begin
            step();
            ready_i = ($urandom_range(0, 3) != 0);
            if (($urandom_range(0, 2) != 0) && (onehot(wi + 1) != read_pointer))
                write_word($urandom, 1);
        end
        step();
        ready_i = 1'b1;
        cyc = 0;
        while ((exp_q.size() != 0 || valid_o) && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        @(negedge clk);
        chk("drain_queue", 64'(exp_q.size()), 64'd0);
        chk("drain_valid", 64'(valid_o), 64'd0);
        chk("drain_empty", 64'(empty), 64'd1);
        chk("drain_terr", 64'(token_error), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/dc_token_ring_reader.md
Name: dc_token_ring_reader

Overview:
- Read-side controller for the dual-clock token-ring FIFO. Runs entirely in the read clock domain.
- Owns the one-hot read pointer into the shared data buffer and compares it with the already-synchronized one-hot write token to detect data.
- Drains the buffer through a registered valid/ready output stage, one word per cycle.
- Feeds its read pointer back to the write side as the read token, which the writer uses for its full check.

Parameters:
- DATA_WIDTH, 32, width of buffer words and data_o.
- BUFFER_DEPTH, 8, number of buffer slots; width of the one-hot pointers/tokens; legal range 2..1024.

Ports:
- clk  input  1  read-domain clock.
- rst  input  1  synchronous reset, active-high.
- write_token  input  BUFFER_DEPTH  one-hot next-write slot, already synchronized into clk.
- read_pointer  output  BUFFER_DEPTH  one-hot slot currently addressed; drives the buffer read port and the write-side read token.
- read_data  input  DATA_WIDTH  combinational buffer word at read_pointer.
- data_o  output  DATA_WIDTH  registered output word.
- valid_o  output  1  data_o holds a word.
- ready_i  input  1  consumer accepts data_o.
- empty  output  1  combinational: no unread slot in the buffer (output register excluded).
- token_error  output  1  sticky flag: write_token was observed not one-hot.

Behaviour:
- Reset (rst=1 at posedge clk): read_pointer=1 (bit 0), data_o=0, valid_o=0, token_error=0. Reset mid-transfer discards any word in data_o.
- Reset to write side: any word already in the buffer is abandoned; the write side resets to slot 0 at the same time.
- empty = (read_pointer == write_token) or token_error.
- Token check: token_err_now = popcount(write_token) != 1. Once token_err_now is seen, token_error=1 from the next cycle until reset.
- Error stall: while token_error=1, no slot is consumed. Any word already in data_o may still be drained.
- Output register state:
  - EMPTY_REG (valid_o=0).
  - FULL_REG (valid_o=1).
- take = !empty and (!valid_o or ready_i).
- On take at posedge:
  - data_o <= read_data.
  - valid_o <= 1.
  - read_pointer rotates left by one; bit BUFFER_DEPTH-1 wraps to bit 0.
- valid_o and ready_i and empty: valid_o <= 0; data_o holds its last value.
- valid_o and !ready_i: data_o, valid_o and read_pointer all hold.
  - data_o must not change while valid_o=1 and ready_i=0.
- Simultaneous pop and take (valid_o=1, ready_i=1, !empty): the new word replaces the old one in the same edge. Sustained throughput is 1 word/cycle.
- Latency: write_token advancing past read_pointer at cycle N gives valid_o=1 at cycle N+1, provided the output register is free.
- ready_i while valid_o=0 is ignored.
- Wrap-around: after BUFFER_DEPTH takes, read_pointer returns to bit 0. No counter width beyond BUFFER_DEPTH bits.
- Capacity: the writer stops when its next token equals read_pointer, so at most BUFFER_DEPTH-1 slots are in flight. The reader does not enforce this.
- read_pointer is always exactly one-hot and is driven straight from a flop, with no logic between the register and the port.

Test Plan:
- Reset then idle, write_token=8'h01 -> read_pointer=8'h01, valid_o=0, empty=1, token_error=0 for 10 cycles.
- Single word: buffer slot 0=32'hDEADBEEF, write_token 8'h01->8'h02 at cycle N, ready_i=1 -> valid_o=1 and data_o=DEADBEEF at N+1, read_pointer=8'h02; valid_o=0 at N+2.
- Streaming with wrap: preload slots 0..6 with 0..6, write_token=8'h80, ready_i=1 -> seven consecutive valid beats with data 0..6, then read_pointer=8'h80 and valid_o=0. Advance write_token to 8'h01 with slot 7=7 -> one more beat of data 7, then read_pointer=8'h01.
- Backpressure: three words pending, ready_i=0 for 5 cycles -> data_o stable at first word and read_pointer advanced only once. Release ready_i -> remaining two words follow on consecutive cycles with no loss or duplication.
- Token fault: drive write_token=8'h03 for one cycle -> token_error=1 the next cycle and stays 1. read_pointer frozen, empty=1. Cleared only by rst.
- Reset mid-stream: assert rst while valid_o=1 and ready_i=0 -> next cycle valid_o=0, data_o=0, read_pointer=8'h01.
